// File: rtl/ccip_if_pkg.sv
// CCI-P Tx channel types used by the VAI request path.
// Header fields are carried opaquely; only their widths matter to the buffers.
package ccip_if_pkg;

    localparam int CCIP_CLDATA_WIDTH   = 512;
    localparam int CCIP_MMIODATA_WIDTH = 64;

    typedef logic [73:0]                    t_ccip_c0_ReqMemHdr;
    typedef logic [79:0]                    t_ccip_c1_ReqMemHdr;
    typedef logic [8:0]                     t_ccip_c2_RspMmioHdr;
    typedef logic [CCIP_CLDATA_WIDTH-1:0]   t_ccip_clData;
    typedef logic [CCIP_MMIODATA_WIDTH-1:0] t_ccip_mmioData;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        t_ccip_mmioData      data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

endpackage

// File: rtl/vai_tx_credit_buffer_pkg.sv
// Shared VAI constants and helpers for the per-sub-AFU Tx buffers.
package vai_tx_credit_buffer_pkg;

    localparam int VAI_DROP_CNT_WIDTH = 16;

    localparam int NUM_CH = 2;
    localparam int CH_C0  = 0;
    localparam int CH_C1  = 1;

    // Saturating increment: a stuck-at-max counter still says "many drops".
    function automatic logic [VAI_DROP_CNT_WIDTH-1:0] satInc(
        input logic [VAI_DROP_CNT_WIDTH-1:0] value
    );
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/vai_tx_fifo.sv
// Synchronous FIFO on an inferred RAM with registered read.
// rdata updates the cycle after a pop, so it doubles as the downstream output register.
module vai_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                     pClk,
    input  logic                     SoftReset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtrReg;
    logic [AW-1:0]    rdPtrReg;
    logic [OW-1:0]    occReg;
    logic [WIDTH-1:0] rdataReg;
    logic             popOk;
    logic             pushOk;

    assign full  = (occReg == OW'(DEPTH));
    assign empty = (occReg == '0);

    // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
    assign popOk  = pop & ~empty;
    assign pushOk = push & (~full | popOk);

    always_ff @(posedge pClk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            occReg   <= '0;
        end else begin
            if (pushOk) wrPtrReg <= wrPtrReg + 1'b1;
            if (popOk)  rdPtrReg <= rdPtrReg + 1'b1;
            occReg <= occReg + OW'(pushOk) - OW'(popOk);
        end
    end

    // Read-first when full with push+pop on the same address: the old head is returned.
    always_ff @(posedge pClk) begin
        if (pushOk) mem[wrPtrReg] <= wdata;
        if (popOk)  rdataReg <= mem[rdPtrReg];
    end

    assign rdata     = rdataReg;
    assign occupancy = occReg;

endmodule

// File: rtl/vai_tx_credit_buffer.sv
// Per-sub-AFU CCI-P Tx buffer: queues c0/c1 requests and drains them while the
// mux is not almost-full, giving the AFU its own almost-full with fixed slack.
module vai_tx_credit_buffer
    import ccip_if_pkg::*;
    import vai_tx_credit_buffer_pkg::*;
#(
    parameter int DEPTH         = 64,
    parameter int ALMFULL_SLACK = 8
) (
    input  logic                          pClk,
    input  logic                          SoftReset_n,
    input  t_if_ccip_Tx                   afu_TxPort,
    output logic                          afu_c0TxAlmFull,
    output logic                          afu_c1TxAlmFull,
    output t_if_ccip_Tx                   mux_TxPort,
    input  logic                          mux_c0TxAlmFull,
    input  logic                          mux_c1TxAlmFull,
    output logic [$clog2(DEPTH):0]        c0_occupancy,
    output logic [$clog2(DEPTH):0]        c1_occupancy,
    output logic [VAI_DROP_CNT_WIDTH-1:0] c0_drop_cnt,
    output logic [VAI_DROP_CNT_WIDTH-1:0] c1_drop_cnt
);

    localparam int OCC_W    = $clog2(DEPTH) + 1;
    localparam int C0_W     = $bits(t_ccip_c0_ReqMemHdr);
    localparam int C1_HDR_W = $bits(t_ccip_c1_ReqMemHdr);
    localparam int C1_W     = C1_HDR_W + CCIP_CLDATA_WIDTH;
    localparam logic [OCC_W-1:0] ALMFULL_THRESH = OCC_W'(DEPTH - ALMFULL_SLACK);

    logic [NUM_CH-1:0]             reqValid;
    logic [NUM_CH-1:0]             muxAlmFull;
    logic [NUM_CH-1:0]             fifoFull;
    logic [NUM_CH-1:0]             fifoEmpty;
    logic [NUM_CH-1:0]             pushReq;
    logic [NUM_CH-1:0]             popReq;
    logic [NUM_CH-1:0]             dropEvt;
    logic [NUM_CH-1:0]             almFullVec;
    logic [NUM_CH-1:0]             muxValidVec;
    logic [OCC_W-1:0]              occ      [NUM_CH];
    logic [OCC_W-1:0]              occNext  [NUM_CH];
    logic [VAI_DROP_CNT_WIDTH-1:0] dropCnt  [NUM_CH];
    logic [C0_W-1:0]               c0Rdata;
    logic [C1_W-1:0]               c1Rdata;
    t_if_ccip_c2_Tx                c2Reg;

    assign reqValid   = {afu_TxPort.c1.valid, afu_TxPort.c0.valid};
    assign muxAlmFull = {mux_c1TxAlmFull, mux_c0TxAlmFull};

    vai_tx_fifo #(
        .WIDTH (C0_W),
        .DEPTH (DEPTH)
    ) c0Fifo (
        .pClk        (pClk),
        .SoftReset_n (SoftReset_n),
        .push        (pushReq[CH_C0]),
        .pop         (popReq[CH_C0]),
        .wdata       (afu_TxPort.c0.hdr),
        .rdata       (c0Rdata),
        .occupancy   (occ[CH_C0]),
        .full        (fifoFull[CH_C0]),
        .empty       (fifoEmpty[CH_C0])
    );

    vai_tx_fifo #(
        .WIDTH (C1_W),
        .DEPTH (DEPTH)
    ) c1Fifo (
        .pClk        (pClk),
        .SoftReset_n (SoftReset_n),
        .push        (pushReq[CH_C1]),
        .pop         (popReq[CH_C1]),
        .wdata       ({afu_TxPort.c1.hdr, afu_TxPort.c1.data}),
        .rdata       (c1Rdata),
        .occupancy   (occ[CH_C1]),
        .full        (fifoFull[CH_C1]),
        .empty       (fifoEmpty[CH_C1])
    );

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic                          almFullReg;
            logic                          muxValidReg;
            logic [VAI_DROP_CNT_WIDTH-1:0] dropCntReg;

            // The mux almost-full is honoured in the cycle it is seen.
            assign popReq[gi]  = ~fifoEmpty[gi] & ~muxAlmFull[gi];
            assign pushReq[gi] = reqValid[gi] & (~fifoFull[gi] | popReq[gi]);
            assign dropEvt[gi] = reqValid[gi] & fifoFull[gi] & ~popReq[gi];
            assign occNext[gi] = occ[gi] + OCC_W'(pushReq[gi]) - OCC_W'(popReq[gi]);

            always_ff @(posedge pClk or negedge SoftReset_n) begin
                if (!SoftReset_n) begin
                    almFullReg  <= 1'b1;
                    muxValidReg <= 1'b0;
                    dropCntReg  <= '0;
                end else begin
                    almFullReg  <= (occNext[gi] >= ALMFULL_THRESH);
                    muxValidReg <= popReq[gi];
                    if (dropEvt[gi]) dropCntReg <= satInc(dropCntReg);
                end
            end

            assign almFullVec[gi]  = almFullReg;
            assign muxValidVec[gi] = muxValidReg;
            assign dropCnt[gi]     = dropCntReg;
        end
    endgenerate

    // MMIO read responses have no backpressure: a plain pipeline stage.
    always_ff @(posedge pClk or negedge SoftReset_n) begin
        if (!SoftReset_n) c2Reg <= '0;
        else              c2Reg <= afu_TxPort.c2;
    end

    always_comb begin
        mux_TxPort          = '0;
        mux_TxPort.c0.hdr   = c0Rdata;
        mux_TxPort.c0.valid = muxValidVec[CH_C0];
        mux_TxPort.c1.hdr   = c1Rdata[C1_W-1 -: C1_HDR_W];
        mux_TxPort.c1.data  = c1Rdata[CCIP_CLDATA_WIDTH-1:0];
        mux_TxPort.c1.valid = muxValidVec[CH_C1];
        mux_TxPort.c2       = c2Reg;
    end

    assign afu_c0TxAlmFull = almFullVec[CH_C0];
    assign afu_c1TxAlmFull = almFullVec[CH_C1];
    assign c0_occupancy    = occ[CH_C0];
    assign c1_occupancy    = occ[CH_C1];
    assign c0_drop_cnt     = dropCnt[CH_C0];
    assign c1_drop_cnt     = dropCnt[CH_C1];

endmodule

// File: tb/tb_vai_tx_credit_buffer.sv
// Randomized bench for vai_tx_credit_buffer against a queue-based reference model.
module tb_vai_tx_credit_buffer;
    import ccip_if_pkg::*;

    localparam int DEPTH = 64;
    localparam int SLACK = 8;
    localparam int C0W   = $bits(t_ccip_c0_ReqMemHdr);
    localparam int C1W   = $bits(t_ccip_c1_ReqMemHdr) + CCIP_CLDATA_WIDTH;
    localparam int C2W   = $bits(t_ccip_c2_RspMmioHdr) + CCIP_MMIODATA_WIDTH;

    logic          pClk = 1'b0;
    logic          SoftReset_n = 1'b0;
    t_if_ccip_Tx   afuTx;
    t_if_ccip_Tx   muxTx;
    logic          afuC0AlmFull, afuC1AlmFull;
    logic          muxC0AlmFull, muxC1AlmFull;
    logic [6:0]    c0Occ, c1Occ;
    logic [15:0]   c0Drop, c1Drop;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: per-channel request queues and the outputs expected next cycle.
    logic [639:0] q0[$];
    logic [639:0] q1[$];
    bit           expV    [2];
    logic [639:0] expD    [2];
    int           expOcc  [2];
    bit           expAF   [2];
    int           expDrop [2];
    bit           expC2v;
    logic [639:0] expC2d;

    vai_tx_credit_buffer #(
        .DEPTH         (DEPTH),
        .ALMFULL_SLACK (SLACK)
    ) dut (
        .pClk            (pClk),
        .SoftReset_n     (SoftReset_n),
        .afu_TxPort      (afuTx),
        .afu_c0TxAlmFull (afuC0AlmFull),
        .afu_c1TxAlmFull (afuC1AlmFull),
        .mux_TxPort      (muxTx),
        .mux_c0TxAlmFull (muxC0AlmFull),
        .mux_c1TxAlmFull (muxC1AlmFull),
        .c0_occupancy    (c0Occ),
        .c1_occupancy    (c1Occ),
        .c0_drop_cnt     (c0Drop),
        .c1_drop_cnt     (c1Drop)
    );

    always #5 pClk = ~pClk;

    task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [639:0] rnd();
        logic [639:0] r;
        for (int i = 0; i < 20; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic modelReset();
        q0.delete();
        q1.delete();
        for (int c = 0; c < 2; c++) begin
            expV[c] = 0; expD[c] = '0; expOcc[c] = 0; expAF[c] = 1; expDrop[c] = 0;
        end
        expC2v = 0;
        expC2d = '0;
    endtask

    // One clock edge of a channel: the head leaves if the mux allows it, then the
    // new request enters if there is room (a departing head makes room).
    task automatic modelStep(input int ch, input bit v, input logic [639:0] pl, input bit af);
        int           sz;
        logic [639:0] head;
        sz = (ch == 0) ? q0.size() : q1.size();
        expV[ch] = (sz > 0) && !af;
        if (expV[ch]) begin
            head = (ch == 0) ? q0.pop_front() : q1.pop_front();
            expD[ch] = head;
            sz--;
        end
        if (v) begin
            if (sz < DEPTH) begin
                if (ch == 0) q0.push_back(pl); else q1.push_back(pl);
                sz++;
            end else if (expDrop[ch] < 16'hFFFF) begin
                expDrop[ch]++;
            end
        end
        expOcc[ch] = sz;
        expAF[ch]  = (sz >= DEPTH - SLACK);
    endtask

    task automatic checkOutputs();
        chk("c0_valid",   640'(muxTx.c0.valid), 640'(expV[0]));
        if (expV[0]) chk("c0_hdr", 640'(muxTx.c0.hdr), expD[0]);
        chk("c0_occ",     640'(c0Occ),          640'(expOcc[0]));
        chk("c0_almfull", 640'(afuC0AlmFull),   640'(expAF[0]));
        chk("c0_drop",    640'(c0Drop),         640'(expDrop[0]));
        chk("c1_valid",   640'(muxTx.c1.valid), 640'(expV[1]));
        if (expV[1]) chk("c1_beat", 640'({muxTx.c1.hdr, muxTx.c1.data}), expD[1]);
        chk("c1_occ",     640'(c1Occ),          640'(expOcc[1]));
        chk("c1_almfull", 640'(afuC1AlmFull),   640'(expAF[1]));
        chk("c1_drop",    640'(c1Drop),         640'(expDrop[1]));
        chk("c2_valid",   640'(muxTx.c2.mmioRdValid), 640'(expC2v));
        if (expC2v) chk("c2_rsp", 640'({muxTx.c2.hdr, muxTx.c2.data}), expC2d);
    endtask

    task automatic driveIdle();
        afuTx        = '0;
        muxC0AlmFull = 1'b0;
        muxC1AlmFull = 1'b0;
    endtask

    // Percent probabilities: c0 valid, c1 valid, mux c0/c1 almost-full, c2 response.
    task automatic runCycles(input int n, input int pv0, input int pv1,
                             input int paf0, input int paf1, input int pc2);
        logic [639:0] r;
        for (int i = 0; i < n; i++) begin
            @(negedge pClk);
            checkOutputs();
            afuTx = '0;
            if ($urandom_range(99) < pv0) begin
                r = rnd();
                afuTx.c0.valid = 1'b1;
                afuTx.c0.hdr   = r[C0W-1:0];
            end
            if ($urandom_range(99) < pv1) begin
                r = rnd();
                afuTx.c1.valid = 1'b1;
                {afuTx.c1.hdr, afuTx.c1.data} = r[C1W-1:0];
            end
            if ($urandom_range(99) < pc2) begin
                r = rnd();
                afuTx.c2.mmioRdValid = 1'b1;
                {afuTx.c2.hdr, afuTx.c2.data} = r[C2W-1:0];
            end
            muxC0AlmFull = ($urandom_range(99) < paf0);
            muxC1AlmFull = ($urandom_range(99) < paf1);
            modelStep(0, afuTx.c0.valid, 640'(afuTx.c0.hdr), muxC0AlmFull);
            modelStep(1, afuTx.c1.valid, 640'({afuTx.c1.hdr, afuTx.c1.data}), muxC1AlmFull);
            expC2v = afuTx.c2.mmioRdValid;
            expC2d = 640'({afuTx.c2.hdr, afuTx.c2.data});
            @(posedge pClk);
        end
    endtask

    // Reset asserted between edges, held across one edge, released between edges.
    task automatic doReset();
        @(negedge pClk);
        checkOutputs();
        SoftReset_n = 1'b0;
        driveIdle();
        #1;
        modelReset();
        checkOutputs();
        @(posedge pClk);
        @(negedge pClk);
        checkOutputs();
        SoftReset_n = 1'b1;
        modelStep(0, 1'b0, '0, 1'b0);
        modelStep(1, 1'b0, '0, 1'b0);
        expC2v = 0;
        @(posedge pClk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        driveIdle();
        modelReset();
        doReset();
        runCycles(40, 10, 0, 0, 0, 20);       // sparse single reads: t+2 latency
        runCycles(80, 0, 80, 0, 100, 0);      // c1 fills behind a stalled mux
        runCycles(80, 0, 0, 0, 0, 30);        // c1 drains in order
        runCycles(70, 100, 0, 100, 0, 50);    // c0 to full plus drops; c2 unaffected
        runCycles(6, 100, 0, 0, 0, 0);        // push and pop together while full
        runCycles(70, 0, 0, 0, 0, 0);
        runCycles(60, 0, 100, 0, 50, 0);      // c1 beats under toggling mux almost-full
        runCycles(200, 60, 60, 30, 30, 30);
        runCycles(25, 100, 0, 100, 0, 0);
        runCycles(3, 0, 0, 0, 0, 0);          // mid-drain, then reset
        doReset();
        runCycles(200, 70, 70, 40, 40, 40);
        runCycles(100, 0, 0, 0, 0, 0);
        @(negedge pClk);
        checkOutputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/vai_tx_credit_buffer.md
# vai_tx_credit_buffer

Per-sub-AFU CCI-P Tx request buffer. It sits between one sub-AFU's Tx port and the matching `afu_TxPort[n]` input of the VAI mux. It absorbs c0 (read) and c1 (write) requests in ordered FIFOs and drains them only while the mux is not asserting almost-full. It gives each sub-AFU its own almost-full with fixed slack, so a congested shared link never makes a well-behaved AFU violate the CCI-P almost-full contract.

## Interface
- `DEPTH`, 64: entries per channel FIFO; power of two, ≥ 16.
- `ALMFULL_SLACK`, 8: free entries remaining when the AFU-side almost-full asserts; 1 ≤ value < DEPTH.
- `pClk` in 1: single clock for the whole block.
- `SoftReset_n` in 1: reset, asynchronous and active-low.
- `afu_TxPort` in `t_if_ccip_Tx`: requests from the sub-AFU; c0, c1 and c2 are used.
- `afu_c0TxAlmFull` out 1: c0 almost-full to the sub-AFU.
- `afu_c1TxAlmFull` out 1: c1 almost-full to the sub-AFU.
- `mux_TxPort` out `t_if_ccip_Tx`: registered requests to the mux input.
- `mux_c0TxAlmFull` in 1: c0 almost-full from the mux (`afu_RxPort[n].c0TxAlmFull`).
- `mux_c1TxAlmFull` in 1: c1 almost-full from the mux.
- `c0_occupancy` out $clog2(DEPTH)+1: current c0 FIFO fill.
- `c1_occupancy` out $clog2(DEPTH)+1: current c1 FIFO fill.
- `c0_drop_cnt` out 16: saturating count of c0 requests dropped on a full FIFO.
- `c1_drop_cnt` out 16: saturating count of c1 requests dropped on a full FIFO.

## Operation
- c0 and c1 are independent, identical channels. Each has one FIFO entry of {hdr, data (c1 only)}.
- Push: `afu_TxPort.cX.valid`=1 and FIFO not full → write the entry.
- Full push: `afu_TxPort.cX.valid`=1 with FIFO full → drop the request and increment `cX_drop_cnt`, saturating at 0xFFFF. This is a protocol violation by the AFU; it must never wedge the block.
- Pop: FIFO not empty and `mux_cXTxAlmFull`=0, sampled in the same cycle → load the head into the `mux_TxPort.cX` register with valid=1.
- Otherwise `mux_TxPort.cX.valid` is 0 on the next cycle. The output register is never held valid for more than one cycle per request.
- Push and pop in the same cycle are both allowed. Occupancy is unchanged, including when the FIFO is full: the pop frees a slot, so the push is accepted.
- Order is strictly preserved per channel. Multi-CL c1 write beats stay contiguous in issue order. A drain may stall between beats.
- AFU-side almost-full: `afu_cXTxAlmFull` is registered `(occupancy_next ≥ DEPTH-ALMFULL_SLACK)`.
- c2 (MMIO read response) has no backpressure. `mux_TxPort.c2` is `afu_TxPort.c2` registered one cycle.
- Occupancy arithmetic is unsigned with width $clog2(DEPTH)+1. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full = occupancy==DEPTH, empty = occupancy==0.

## Timing
- Latency, empty FIFO and mux almost-full low: request valid in cycle t is valid on `mux_TxPort` in cycle t+2.
- Throughput: 1 request per channel per cycle sustained.
- `afu_cXTxAlmFull` asserts the cycle after the push that reaches the threshold. It deasserts the cycle after the pop that brings occupancy below it.
- `mux_cXTxAlmFull` rising in cycle t: no pop in cycle t. At most one request, already registered, is presented in cycle t. This stays within the mux's slack.
- Reset asserted, at any time and asynchronously:
  - all `mux_TxPort` valids = 0;
  - occupancies = 0 and pointers = 0, with FIFO contents discarded;
  - drop counters = 0;
  - `afu_cXTxAlmFull` = 1.
- First edge after reset release: almost-full outputs go to 0.
- In-flight requests at reset are lost, not replayed.

## Structure
- Types come from `ccip_if_pkg` (`t_if_ccip_c0_Tx`, `t_if_ccip_c1_Tx`, `t_if_ccip_c2_Tx`). No new typedefs.
- The drop-counter width (16) is a package constant in the shared VAI package.
- One sub-module, `vai_tx_fifo`: parameterised width/depth synchronous FIFO.
  - Ports: push, pop, wdata, rdata, occupancy, full, empty.
  - Instantiated twice: c0 width = header; c1 width = header + 512-bit data.

## Test plan
- Single c0 read, mux almost-full low → `mux_TxPort.c0` valid exactly in cycle t+2 with an identical header; `c0_occupancy` goes 1 then 0.
- Hold `mux_c1TxAlmFull`=1 and push 56 writes (DEPTH=64) → `afu_c1TxAlmFull`=1 from the cycle after the 56th push. Release → 56 writes drain in order, one per cycle, and almost-full drops after occupancy < 56.
- Fill c0 to 64, then push 3 more with no drain → `c0_drop_cnt`=3, occupancy stays 64. Then push and pop in the same cycle while full → the push is accepted and occupancy stays 64.
- 4-beat multi-CL c1 write with mux almost-full toggled each cycle → beats emerge in order, contiguous, and none are lost or duplicated.
- Deassert `SoftReset_n` mid-drain with occupancy 20 → outputs invalid immediately, occupancy 0. After release: almost-full is 1 for one cycle, then 0.
- c2 MMIO response while c0/c1 are stalled → appears on `mux_TxPort.c2` one cycle later, unaffected by the stall.
